// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared playfield definitions for the snake game blocks.
//   GRID_W / GRID_H : playfield size in cells (legal x 0..29, y 0..19)
//   COORD_W         : coordinate width
//   coord_t         : one coordinate
//   placer_state_t  : apple placer FSM states
// ---------------------------------------------------------------------------
package snake_pkg;

   localparam int GRID_W  = 30;
   localparam int GRID_H  = 20;
   localparam int COORD_W = 5;

   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t GRID_W_C = coord_t'(GRID_W);
   localparam coord_t GRID_H_C = coord_t'(GRID_H);
   localparam coord_t X_MAX    = coord_t'(GRID_W - 1);
   localparam coord_t Y_MAX    = coord_t'(GRID_H - 1);
   localparam coord_t COORD_1  = coord_t'(1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PICK       = 3'd1,
      ST_PROBE      = 3'd2,
      ST_CHECK      = 3'd3,
      ST_SCAN_PROBE = 3'd4,
      ST_SCAN_CHECK = 3'd5,
      ST_FULL       = 3'd6
   } placer_state_t;

   // Full-width compare: out-of-grid values are rejected, never wrapped.
   function automatic logic in_grid(input coord_t x, input coord_t y);
      return (x < GRID_W_C) && (y < GRID_H_C);
   endfunction

endpackage

// File: rtl/grid_scan_ctr.sv
// ---------------------------------------------------------------------------
// grid_scan_ctr
// Row-major x/y cell counter over the playfield.
//   clk, rst       : clock, async active-high reset (counter -> (0,0))
//   i_clear        : restart at (0,0)
//   i_adv          : step to next cell (x first, then y)
//   o_x, o_y       : current cell
//   o_nx, o_ny     : cell that i_adv would move to
//   o_last         : current cell is the bottom-right cell
// ---------------------------------------------------------------------------
module grid_scan_ctr
   import snake_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_adv,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic [COORD_W-1:0] o_nx,
   output logic [COORD_W-1:0] o_ny,
   output logic               o_last
);

   coord_t r_x;
   coord_t r_y;
   logic   w_row_end;

   assign w_row_end = (r_x == X_MAX);
   assign o_x       = r_x;
   assign o_y       = r_y;
   assign o_nx      = w_row_end ? '0 : r_x + COORD_1;
   assign o_ny      = w_row_end ? r_y + COORD_1 : r_y;
   assign o_last    = w_row_end && (r_y == Y_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_clear) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_adv) begin
         r_x <= o_nx;
         r_y <= o_ny;
      end
   end

endmodule

// File: rtl/apple_placer.sv
// ---------------------------------------------------------------------------
// apple_placer
// Turns free-running random coordinates into a legal apple position: range
// check, occupancy query, retry on collision, optional row-major scan.
// Optional feature macro: APPLE_SCAN_FALLBACK_EN (scan fallback + FULL state).
//   clk, rst          : clock, async active-high reset
//   rand_x, rand_y    : random candidate, new every cycle
//   eat               : pulse in IDLE starts a new placement
//   occ_req/x/y       : registered occupancy query
//   occ_hit           : query answer, one cycle after occ_req
//   apple_x/y, apple_valid : current apple
//   busy              : placement in progress
//   board_full        : no free cell (sticky until rst), 0 without scan
//   dbg_state         : FSM state (placer_state_t encoding)
// Handshake: occ_req is a single-cycle strobe with no back-pressure; occ_hit
// is only looked at in the cycle right after the strobe.
// ---------------------------------------------------------------------------
module apple_placer
   import snake_pkg::*;
#(
   parameter int MAX_TRIES = 8,
   parameter int INIT_X    = 2,
   parameter int INIT_Y    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] rand_x,
   input  logic [COORD_W-1:0] rand_y,
   input  logic               eat,
   output logic               occ_req,
   output logic [COORD_W-1:0] occ_x,
   output logic [COORD_W-1:0] occ_y,
   input  logic               occ_hit,
   output logic [COORD_W-1:0] apple_x,
   output logic [COORD_W-1:0] apple_y,
   output logic               apple_valid,
   output logic               busy,
   output logic               board_full,
   output logic [2:0]         dbg_state
);

   localparam logic [7:0] MAX_T   = 8'(MAX_TRIES);
   localparam coord_t     INIT_XC = coord_t'(INIT_X);
   localparam coord_t     INIT_YC = coord_t'(INIT_Y);

   placer_state_t r_state, w_state;
   logic [7:0]    r_tries, w_tries, w_tries_inc;
   coord_t        r_cand_x, r_cand_y, w_cand_x, w_cand_y;
   coord_t        r_apple_x, r_apple_y, w_apple_x, w_apple_y;
   coord_t        r_occ_x, r_occ_y, w_occ_x, w_occ_y;
   logic          r_apple_valid, w_apple_valid;
   logic          r_busy, w_busy;
   logic          r_occ_req, w_occ_req;
   logic          w_fallback;

`ifdef APPLE_SCAN_FALLBACK_EN
   logic   r_board_full, w_board_full;
   logic   w_scan_clr, w_scan_adv, w_scan_last;
   coord_t w_scan_x, w_scan_y, w_scan_nx, w_scan_ny;

   grid_scan_ctr u_scan (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_scan_clr),
      .i_adv   (w_scan_adv),
      .o_x     (w_scan_x),
      .o_y     (w_scan_y),
      .o_nx    (w_scan_nx),
      .o_ny    (w_scan_ny),
      .o_last  (w_scan_last)
   );

   assign board_full = r_board_full;
`else
   assign board_full = 1'b0;
`endif

   assign w_tries_inc = r_tries + 8'd1;

   always_comb begin
      w_state       = r_state;
      w_tries       = r_tries;
      w_cand_x      = r_cand_x;
      w_cand_y      = r_cand_y;
      w_apple_x     = r_apple_x;
      w_apple_y     = r_apple_y;
      w_apple_valid = r_apple_valid;
      w_busy        = r_busy;
      w_occ_req     = 1'b0;
      w_occ_x       = r_occ_x;
      w_occ_y       = r_occ_y;
      w_fallback    = 1'b0;
`ifdef APPLE_SCAN_FALLBACK_EN
      w_board_full  = r_board_full;
      w_scan_clr    = 1'b0;
      w_scan_adv    = 1'b0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (eat) begin
               w_apple_valid = 1'b0;
               w_busy        = 1'b1;
               w_tries       = '0;
               w_state       = ST_PICK;
            end
         end
         ST_PICK: begin
            w_cand_x = rand_x;
            w_cand_y = rand_y;
            w_tries  = w_tries_inc;
            if (in_grid(rand_x, rand_y)) begin
               // Query is registered, so it is issued on entry to PROBE.
               w_occ_req = 1'b1;
               w_occ_x   = rand_x;
               w_occ_y   = rand_y;
               w_state   = ST_PROBE;
            end else if (w_tries_inc == MAX_T) begin
               w_fallback = 1'b1;
            end
         end
         ST_PROBE: w_state = ST_CHECK;
         ST_CHECK: begin
            if (!occ_hit) begin
               w_apple_x     = r_cand_x;
               w_apple_y     = r_cand_y;
               w_apple_valid = 1'b1;
               w_busy        = 1'b0;
               w_state       = ST_IDLE;
            end else if (r_tries < MAX_T) begin
               w_state = ST_PICK;
            end else begin
               w_fallback = 1'b1;
            end
         end
`ifdef APPLE_SCAN_FALLBACK_EN
         ST_SCAN_PROBE: w_state = ST_SCAN_CHECK;
         ST_SCAN_CHECK: begin
            if (!occ_hit) begin
               w_apple_x     = w_scan_x;
               w_apple_y     = w_scan_y;
               w_apple_valid = 1'b1;
               w_busy        = 1'b0;
               w_state       = ST_IDLE;
            end else if (w_scan_last) begin
               w_board_full  = 1'b1;
               w_apple_valid = 1'b0;
               w_busy        = 1'b0;
               w_state       = ST_FULL;
            end else begin
               w_scan_adv = 1'b1;
               w_occ_req  = 1'b1;
               w_occ_x    = w_scan_nx;
               w_occ_y    = w_scan_ny;
               w_state    = ST_SCAN_PROBE;
            end
         end
         ST_FULL: w_state = ST_FULL;
`endif
         default: w_state = r_state;
      endcase

      if (w_fallback) begin
`ifdef APPLE_SCAN_FALLBACK_EN
         w_scan_clr = 1'b1;
         w_occ_req  = 1'b1;
         w_occ_x    = '0;
         w_occ_y    = '0;
         w_state    = ST_SCAN_PROBE;
`else
         w_tries = '0;
         w_state = ST_PICK;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_tries       <= '0;
         r_cand_x      <= '0;
         r_cand_y      <= '0;
         r_apple_x     <= INIT_XC;
         r_apple_y     <= INIT_YC;
         r_apple_valid <= 1'b1;
         r_busy        <= 1'b0;
         r_occ_req     <= 1'b0;
         r_occ_x       <= '0;
         r_occ_y       <= '0;
`ifdef APPLE_SCAN_FALLBACK_EN
         r_board_full  <= 1'b0;
`endif
      end else begin
         r_state       <= w_state;
         r_tries       <= w_tries;
         r_cand_x      <= w_cand_x;
         r_cand_y      <= w_cand_y;
         r_apple_x     <= w_apple_x;
         r_apple_y     <= w_apple_y;
         r_apple_valid <= w_apple_valid;
         r_busy        <= w_busy;
         r_occ_req     <= w_occ_req;
         r_occ_x       <= w_occ_x;
         r_occ_y       <= w_occ_y;
`ifdef APPLE_SCAN_FALLBACK_EN
         r_board_full  <= w_board_full;
`endif
      end
   end

   assign occ_req     = r_occ_req;
   assign occ_x       = r_occ_x;
   assign occ_y       = r_occ_y;
   assign apple_x     = r_apple_x;
   assign apple_y     = r_apple_y;
   assign apple_valid = r_apple_valid;
   assign busy        = r_busy;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_apple_placer.sv
`timescale 1ns/1ps
module tb_apple_placer;
   import snake_pkg::*;

   localparam int MAXT = 8;
   localparam int W    = 26;   // {cycle offset[15:0], x[4:0], y[4:0]}
   localparam int LIM  = 2048;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rand_x, rand_y;
   logic       eat, occ_hit;
   logic       occ_req;
   logic [4:0] occ_x, occ_y, apple_x, apple_y;
   logic       apple_valid, busy, board_full;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   apple_placer #(.MAX_TRIES(MAXT), .INIT_X(2), .INIT_Y(2)) dut (
      .clk(clk), .rst(rst), .rand_x(rand_x), .rand_y(rand_y), .eat(eat),
      .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
      .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
      .busy(busy), .board_full(board_full), .dbg_state(dbg_state)
   );

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           eat_cyc = 0;
   int           bad_req = 0;
   bit           occ_map [32][32];
   logic [4:0]   rx [LIM];
   logic [4:0]   ry [LIM];
   bit           espam [LIM];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] act_q[$];

   // ---------------- occupancy store model + query monitor ----------------
   bit         pend = 1'b0;
   logic [4:0] px = '0, py = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pend) occ_hit = occ_map[px][py];
      else      occ_hit = 1'($urandom_range(0, 1));
      pend = occ_req;
      if (occ_req) begin
         px = occ_x;
         py = occ_y;
         act_q.push_back({16'(cyc - eat_cyc), occ_x, occ_y});
         if (!(occ_x < 5'd30 && occ_y < 5'd20)) bad_req++;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_map();
      for (int x = 0; x < 32; x++)
         for (int y = 0; y < 32; y++) occ_map[x][y] = 1'b0;
   endtask

   task automatic fill_rand(input logic [4:0] x, input logic [4:0] y);
      for (int k = 0; k < LIM; k++) begin
         rx[k] = x; ry[k] = y; espam[k] = 1'b0;
      end
   endtask

   // Reference: walks the candidate stream in PICK opportunities.
   // Out-of-grid pick costs 1 cycle, occupied in-grid pick costs 3,
   // scan costs 2 per cell; a free cell becomes valid 1 cycle after its check.
   task automatic model(output int vk, output logic [4:0] ax, output logic [4:0] ay,
                        output bit full, output bit ok);
      int t, tries, s;
      logic [4:0] cx, cy;
      exp_q.delete();
      ok = 0; full = 0; vk = 0; ax = '0; ay = '0;
      t = 1; tries = 0; s = 0; cx = '0; cy = '0;
      while (t < 1500) begin
         tries++;
         if (rx[t] < 5'd30 && ry[t] < 5'd20) begin
            exp_q.push_back({16'(t + 1), rx[t], ry[t]});
            if (!occ_map[rx[t]][ry[t]]) begin
               vk = t + 3; ax = rx[t]; ay = ry[t]; ok = 1;
               return;
            end
            t += 3;
         end else begin
            t += 1;
         end
         if (tries == MAXT) begin
`ifdef APPLE_SCAN_FALLBACK_EN
            s = t;
            for (int i = 0; i < GRID_W * GRID_H; i++) begin
               cx = 5'(i % GRID_W);
               cy = 5'(i / GRID_W);
               exp_q.push_back({16'(s + 2 * i), cx, cy});
               if (!occ_map[cx][cy]) begin
                  vk = s + 2 * i + 2; ax = cx; ay = cy; ok = 1;
                  return;
               end
            end
            vk = s + 2 * GRID_W * GRID_H; full = 1; ok = 1;
            return;
`else
            tries = 0;
`endif
         end
      end
   endtask

   // Driver: eat pulse, stream rx/ry, spam eat while busy, then score.
   task automatic place(input string tag, output int lat);
      int vk, k;
      logic [4:0] ax, ay, hx, hy;
      bit full, ok, done, hold_bad;
      model(vk, ax, ay, full, ok);
      if (!ok) begin
         clear_map();
         model(vk, ax, ay, full, ok);
      end
      hx = apple_x; hy = apple_y; hold_bad = 0; bad_req = 0;
      @(negedge clk);
      act_q.delete();
      eat = 1'b1; rand_x = rx[0]; rand_y = ry[0]; eat_cyc = cyc;
      k = 0; done = 0;
      while (!done && k < 1400) begin
         @(negedge clk);
         k++;
         if (apple_valid || board_full) begin
            done = 1; eat = 1'b0;
         end else begin
            if (apple_x !== hx || apple_y !== hy || busy !== 1'b1) hold_bad = 1;
            eat = espam[k]; rand_x = rx[k]; rand_y = ry[k];
         end
      end
      eat = 1'b0;
      lat = k;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_lat"}, 32'(k), 32'(vk));
      check({tag, "_valid"}, 32'(apple_valid), 32'(!full));
      check({tag, "_full"}, 32'(board_full), 32'(full));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(hold_bad), 32'd0);
      check({tag, "_range"}, 32'(bad_req), 32'd0);
      if (!full) begin
         check({tag, "_ax"}, 32'(apple_x), 32'(ax));
         check({tag, "_ay"}, 32'(apple_y), 32'(ay));
      end
      check({tag, "_nprobe"}, 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check({tag, "_probe"}, 32'(act_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      rst = 1'b1; eat = 1'b0; rand_x = '0; rand_y = '0;
      clear_map();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_ax", 32'(apple_x), 32'd2);
      check("rst_ay", 32'(apple_y), 32'd2);
      check("rst_valid", 32'(apple_valid), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(board_full), 32'd0);
      check("rst_occreq", 32'(occ_req), 32'd0);
      check("rst_occxy", 32'({occ_x, occ_y}), 32'd0);
      check("rst_noreq", 32'(act_q.size()), 32'd0);

      // best case, with an ignored eat during PROBE
      fill_rand(5'd5, 5'd7);
      espam[2] = 1'b1;
      place("basic", lat);
      check("basic_lat_c", 32'(lat), 32'd4);
      check("basic_apple_c", 32'({apple_x, apple_y}), 32'({5'd5, 5'd7}));

      // two out-of-range candidates first
      fill_rand(5'd6, 5'd6);
      rx[1] = 5'd31; ry[1] = 5'd3;
      rx[2] = 5'd4;  ry[2] = 5'd25;
      place("oor", lat);
      check("oor_lat_c", 32'(lat), 32'd6);
      check("oor_nprobe_c", 32'(act_q.size()), 32'd1);

`ifdef APPLE_SCAN_FALLBACK_EN
      // retries exhausted, scan finds (2,0)
      clear_map();
      occ_map[3][3] = 1'b1; occ_map[0][0] = 1'b1; occ_map[1][0] = 1'b1;
      fill_rand(5'd3, 5'd3);
      place("scan", lat);
      check("scan_apple_c", 32'({apple_x, apple_y}), 32'({5'd2, 5'd0}));
      check("scan_nprobe_c", 32'(act_q.size()), 32'd11);
      check("scan_lat_c", 32'(lat), 32'd31);

      // board full, eat ignored, reset recovers
      for (int x = 0; x < 32; x++)
         for (int y = 0; y < 32; y++) occ_map[x][y] = 1'b1;
      place("full", lat);
      check("full_lat_c", 32'(lat), 32'(MAXT * 3 + 2 * GRID_W * GRID_H + 1));
      act_q.delete();
      eat = 1'b1;
      @(negedge clk);
      eat = 1'b0;
      repeat (4) @(negedge clk);
      check("full_sticky", 32'(board_full), 32'd1);
      check("full_idle_busy", 32'(busy), 32'd0);
      check("full_idle_valid", 32'(apple_valid), 32'd0);
      check("full_noreq", 32'(act_q.size()), 32'd0);
      rst = 1'b1;
      #1;
      check("full_rst_full", 32'(board_full), 32'd0);
      check("full_rst_apple", 32'({apple_valid, apple_x, apple_y}), 32'({1'b1, 5'd2, 5'd2}));
      @(negedge clk);
      rst = 1'b0;
      clear_map();
`else
      // no scan: keeps retrying until a free candidate shows up
      clear_map();
      occ_map[3][3] = 1'b1;
      fill_rand(5'd4, 5'd4);
      for (int k = 0; k < 60; k++) begin
         rx[k] = 5'd3; ry[k] = 5'd3;
      end
      place("retry", lat);
      check("retry_apple_c", 32'({apple_x, apple_y}), 32'({5'd4, 5'd4}));
      check("retry_nprobe_c", 32'(act_q.size()), 32'd21);
      clear_map();
`endif

      // reset pulse while in CHECK
      @(negedge clk);
      eat = 1'b1; rand_x = 5'd9; rand_y = 5'd9;
      @(negedge clk);
      eat = 1'b0;
      @(negedge clk);
      eat = 1'b1;
      @(negedge clk);
      eat = 1'b0;
      check("midrst_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_apple", 32'({apple_x, apple_y}), 32'({5'd2, 5'd2}));
      check("midrst_valid", 32'(apple_valid), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_occ", 32'({occ_req, occ_x, occ_y}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      fill_rand(5'd12, 5'd4);
      place("post_rst", lat);
      check("post_rst_lat_c", 32'(lat), 32'd4);

      // randomized placements
      for (int trial = 0; trial < 30; trial++) begin
         int dens;
         dens = $urandom_range(0, 60);
         for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
               occ_map[x][y] = ($urandom_range(0, 99) < dens);
         for (int k = 0; k < LIM; k++) begin
            rx[k] = 5'($urandom_range(0, 31));
            ry[k] = 5'($urandom_range(0, 31));
            espam[k] = ($urandom_range(0, 7) == 0);
         end
         place("rand", lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
